// File: rtl/mem_stage_8bit.sv
// Memory stage behind the 8-bit execute unit: owns the stack pointer, runs
// LDD/STD, PUSH/POP and CALL/RET/INT stacking over a req/ack memory port.
module mem_stage_8bit #(
  parameter logic [7:0] SP_RESET = 8'hFF,
  parameter int         MAX_WAIT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic       MR,
  input  logic       MW,
  input  logic       WB,
  input  logic       SP,
  input  logic       SPOP,
  input  logic       JWSP,
  input  logic       Stack_PC,
  input  logic       Stack_Flags,
  input  logic [2:0] WB_Address,
  input  logic [7:0] Address_8bit,
  input  logic [7:0] Data_8bit,
  input  logic [3:0] Final_Flags,
  input  logic [7:0] PC_8bit,
  output logic       stall,
  output logic       mem_req,
  output logic       mem_we,
  output logic [7:0] mem_addr,
  output logic [7:0] mem_wdata,
  input  logic [7:0] mem_rdata,
  input  logic       mem_ack,
  output logic       out_valid,
  output logic       WB_Out,
  output logic [2:0] WB_Address_Out,
  output logic [7:0] WB_Data,
  output logic       PC_Load,
  output logic [7:0] PC_Value,
  output logic       MEM_Stack_Flags,
  output logic [3:0] Flags_From_Memory,
  output logic [7:0] SP_Value,
  output logic       mem_err,
  output logic [1:0] dbg_state
);

  // Handshakes: upstream op transfers on an edge where in_valid=1 and stall=0
  // (stall is also raised combinationally in the accepting cycle of a memory op);
  // memory access completes on an edge where mem_req=1 and mem_ack=1, with
  // address/we/wdata held constant while mem_req=1; out_valid is a one-cycle strobe.

  typedef enum logic [1:0] {IDLE = 2'd0, ACC = 2'd1, ACC2 = 2'd2, DONE = 2'd3} state_t;

  localparam int CW = $clog2(MAX_WAIT + 1);

  state_t        state;
  logic [CW-1:0] wait_cnt;
  logic [7:0]    sp;

  logic       l_wb, l_mr, l_sp, l_spop, l_jwsp, l_spc, l_sfl;
  logic [2:0] l_wba;
  logic [7:0] l_data;
  logic [3:0] l_flags;
  logic [3:0] flags_byte;

  logic mem_op, can_accept, accept_mem, accept_alu, busy;
  logic is_push, is_pop, two_step, is_read, pc_jump, timeout;

  assign mem_op     = MR | MW | SP;
  assign can_accept = (state == IDLE) || (state == DONE);
  assign accept_mem = can_accept & in_valid & mem_op;
  assign accept_alu = can_accept & in_valid & ~mem_op;
  assign busy       = (state == ACC) || (state == ACC2);
  assign stall      = busy | accept_mem;

  assign is_push  = l_sp & ~l_spop;
  assign is_pop   = l_sp & l_spop;
  assign two_step = (state == ACC) & l_sp & l_sfl;
  assign is_read  = l_mr | is_pop;
  assign pc_jump  = is_pop & l_spc & l_jwsp;
  assign timeout  = busy & ~mem_ack & (wait_cnt == CW'(MAX_WAIT - 1));

  assign SP_Value  = sp;
  assign dbg_state = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= IDLE;
      wait_cnt          <= '0;
      sp                <= SP_RESET;
      mem_req           <= 1'b0;
      mem_we            <= 1'b0;
      mem_addr          <= 8'h00;
      mem_wdata         <= 8'h00;
      out_valid         <= 1'b0;
      WB_Out            <= 1'b0;
      WB_Address_Out    <= 3'd0;
      WB_Data           <= 8'h00;
      PC_Load           <= 1'b0;
      PC_Value          <= 8'h00;
      MEM_Stack_Flags   <= 1'b0;
      Flags_From_Memory <= 4'h0;
      mem_err           <= 1'b0;
      l_wb              <= 1'b0;
      l_mr              <= 1'b0;
      l_sp              <= 1'b0;
      l_spop            <= 1'b0;
      l_jwsp            <= 1'b0;
      l_spc             <= 1'b0;
      l_sfl             <= 1'b0;
      l_wba             <= 3'd0;
      l_data            <= 8'h00;
      l_flags           <= 4'h0;
      flags_byte        <= 4'h0;
    end else begin
      out_valid       <= 1'b0;
      WB_Out          <= 1'b0;
      PC_Load         <= 1'b0;
      MEM_Stack_Flags <= 1'b0;
      case (state)
        IDLE, DONE: begin
          state <= IDLE;
          if (accept_alu) begin
            out_valid      <= 1'b1;
            WB_Out         <= WB;
            WB_Address_Out <= WB_Address;
            WB_Data        <= Data_8bit;
          end else if (accept_mem) begin
            state    <= ACC;
            wait_cnt <= '0;
            mem_req  <= 1'b1;
            l_wb     <= WB;
            l_mr     <= MR & ~SP;
            l_sp     <= SP;
            l_spop   <= SPOP;
            l_jwsp   <= JWSP;
            l_spc    <= Stack_PC;
            l_sfl    <= Stack_Flags;
            l_wba    <= WB_Address;
            l_data   <= Data_8bit;
            l_flags  <= Final_Flags;
            if (SP && !SPOP) begin
              mem_we    <= 1'b1;
              mem_addr  <= sp;
              mem_wdata <= Stack_PC ? PC_8bit + 8'd1 : Data_8bit;
            end else if (SP) begin
              // SP points at the next free slot, so the top of stack is SP+1
              mem_we    <= 1'b0;
              mem_addr  <= sp + 8'd1;
              mem_wdata <= 8'h00;
            end else begin
              mem_we    <= MW;
              mem_addr  <= Address_8bit;
              mem_wdata <= Data_8bit;
            end
          end
        end
        ACC, ACC2: begin
          if (mem_ack) begin
            if (is_push)
              sp <= sp - 8'd1;
            else if (is_pop)
              sp <= sp + 8'd1;
            if (two_step) begin
              // Second stack byte: push stores flags after PC, pop reads PC after flags
              state    <= ACC2;
              wait_cnt <= '0;
              if (is_push) begin
                mem_addr  <= sp - 8'd1;
                mem_wdata <= {4'b0000, l_flags};
              end else begin
                mem_addr   <= sp + 8'd2;
                flags_byte <= mem_rdata[3:0];
              end
            end else begin
              state          <= DONE;
              mem_req        <= 1'b0;
              mem_we         <= 1'b0;
              mem_addr       <= 8'h00;
              mem_wdata      <= 8'h00;
              out_valid      <= 1'b1;
              WB_Out         <= l_wb & ~pc_jump;
              WB_Address_Out <= l_wba;
              WB_Data        <= is_read ? mem_rdata : l_data;
              PC_Load        <= pc_jump;
              if (pc_jump)
                PC_Value <= mem_rdata;
              if (is_pop && l_sfl) begin
                MEM_Stack_Flags   <= 1'b1;
                Flags_From_Memory <= flags_byte;
              end
            end
          end else if (timeout) begin
            // Abandon the access: complete with no side effects except the sticky error
            state          <= DONE;
            mem_err        <= 1'b1;
            mem_req        <= 1'b0;
            mem_we         <= 1'b0;
            mem_addr       <= 8'h00;
            mem_wdata      <= 8'h00;
            out_valid      <= 1'b1;
            WB_Address_Out <= l_wba;
            WB_Data        <= l_data;
          end else begin
            wait_cnt <= wait_cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_8bit.sv
// Bench for mem_stage_8bit: directed stack/timeout/reset scenarios plus random ops
// checked against a byte-array memory and stack-pointer model.
module tb_mem_stage_8bit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, MR, MW, WB, SP, SPOP, JWSP, Stack_PC, Stack_Flags;
  logic [2:0] WB_Address;
  logic [7:0] Address_8bit, Data_8bit, PC_8bit;
  logic [3:0] Final_Flags;
  logic       stall, mem_req, mem_we, mem_ack;
  logic [7:0] mem_addr, mem_wdata, mem_rdata;
  logic       out_valid, WB_Out, PC_Load, MEM_Stack_Flags, mem_err;
  logic [2:0] WB_Address_Out;
  logic [7:0] WB_Data, PC_Value, SP_Value;
  logic [3:0] Flags_From_Memory;
  logic [1:0] dbg_state;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] ram [256];
  logic [7:0] m_sp;

  mem_stage_8bit #(.SP_RESET(8'hFF), .MAX_WAIT(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .MR(MR), .MW(MW), .WB(WB), .SP(SP), .SPOP(SPOP), .JWSP(JWSP),
    .Stack_PC(Stack_PC), .Stack_Flags(Stack_Flags), .WB_Address(WB_Address),
    .Address_8bit(Address_8bit), .Data_8bit(Data_8bit), .Final_Flags(Final_Flags),
    .PC_8bit(PC_8bit), .stall(stall), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .out_valid(out_valid), .WB_Out(WB_Out), .WB_Address_Out(WB_Address_Out),
    .WB_Data(WB_Data), .PC_Load(PC_Load), .PC_Value(PC_Value),
    .MEM_Stack_Flags(MEM_Stack_Flags), .Flags_From_Memory(Flags_From_Memory),
    .SP_Value(SP_Value), .mem_err(mem_err), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit mr, mw, wb, sp, spop, jwsp, spc, sfl,
                       input logic [2:0] wba, input logic [7:0] addr, data,
                       input logic [3:0] flags, input logic [7:0] pc);
    MR = mr; MW = mw; WB = wb; SP = sp; SPOP = spop; JWSP = jwsp;
    Stack_PC = spc; Stack_Flags = sfl; WB_Address = wba;
    Address_8bit = addr; Data_8bit = data; Final_Flags = flags; PC_8bit = pc;
    in_valid = 1'b1;
  endtask

  // Called just after a negedge; returns just after the negedge following out_valid.
  task automatic run_op(input bit mr, mw, wb, sp, spop, jwsp, spc, sfl,
                        input logic [2:0] wba, input logic [7:0] addr, data,
                        input logic [3:0] flags, input logic [7:0] pc, input int lat);
    logic [16:0] acc_q[$];
    logic [7:0]  rd_q[$];
    logic [16:0] a;
    logic [7:0]  first_rd, last_rd;
    bit memop, rd, jump, msf;
    memop = mr || mw || sp;
    if (sp && !spop) begin
      acc_q.push_back({1'b1, m_sp, spc ? pc + 8'd1 : data});
      m_sp = m_sp - 8'd1;
      if (sfl) begin
        acc_q.push_back({1'b1, m_sp, 4'b0000, flags});
        m_sp = m_sp - 8'd1;
      end
    end else if (sp) begin
      repeat (sfl ? 2 : 1) begin
        m_sp = m_sp + 8'd1;
        acc_q.push_back({1'b0, m_sp, 8'h00});
        rd_q.push_back(ram[m_sp]);
      end
    end else if (mr || mw) begin
      acc_q.push_back({mw, addr, data});
      if (mr) rd_q.push_back(ram[addr]);
    end
    rd   = mr || (sp && spop);
    jump = sp && spop && spc && jwsp;
    msf  = sp && spop && sfl;
    first_rd = 8'h00;
    last_rd  = 8'h00;
    if (rd_q.size() > 0) begin
      first_rd = rd_q[0];
      last_rd  = rd_q[rd_q.size() - 1];
    end

    drive(mr, mw, wb, sp, spop, jwsp, spc, sfl, wba, addr, data, flags, pc);
    #1 chk("accept_stall", stall, memop);
    @(negedge clk);
    in_valid = 1'b0;
    foreach (acc_q[i]) begin
      a = acc_q[i];
      chk("req", mem_req, 1);
      chk("addr", mem_addr, a[15:8]);
      chk("we", mem_we, a[16]);
      if (a[16]) chk("wdata", mem_wdata, a[7:0]);
      for (int k = 1; k < lat; k++) begin
        chk("stall_busy", stall, 1);
        @(negedge clk);
        chk("addr_stable", mem_addr, a[15:8]);
      end
      mem_ack   = 1'b1;
      mem_rdata = a[16] ? 8'($urandom) : ram[a[15:8]];
      @(negedge clk);
      mem_ack   = 1'b0;
      mem_rdata = 8'h00;
      if (a[16]) ram[a[15:8]] = a[7:0];
    end
    chk("out_valid", out_valid, 1);
    chk("done_stall", stall, 0);
    chk("done_req", mem_req, 0);
    chk("done_addr", mem_addr, 0);
    chk("wb_addr", WB_Address_Out, wba);
    chk("wb_out", WB_Out, wb && !jump);
    chk("wb_data", WB_Data, rd ? last_rd : data);
    chk("pc_load", PC_Load, jump);
    if (jump) chk("pc_value", PC_Value, last_rd);
    chk("msf", MEM_Stack_Flags, msf);
    if (msf) chk("flags_mem", Flags_From_Memory, first_rd[3:0]);
    chk("sp", SP_Value, m_sp);
    chk("no_err", mem_err, 0);
    @(negedge clk);
    chk("strobe_end", out_valid, 0);
  endtask

  initial begin
    logic [7:0] d, ad, p;
    logic [3:0] f;
    logic [2:0] w;
    int kind, lat;
    rst_n = 1'b0;
    in_valid = 1'b0; MR = 0; MW = 0; WB = 0; SP = 0; SPOP = 0; JWSP = 0;
    Stack_PC = 0; Stack_Flags = 0; WB_Address = 0; Address_8bit = 0;
    Data_8bit = 0; Final_Flags = 0; PC_8bit = 0; mem_ack = 0; mem_rdata = 0;
    for (int i = 0; i < 256; i++) ram[i] = 8'($urandom);
    m_sp = 8'hFF;
    repeat (2) @(negedge clk);
    chk("rst_sp", SP_Value, 8'hFF);
    chk("rst_req", mem_req, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_stall", stall, 0);
    chk("rst_err", mem_err, 0);
    chk("rst_wbdata", WB_Data, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Push 5A with 2-cycle ack, then pop it back
    run_op(0,0,0,1,0,0,0,0, 3'd0, 8'h00, 8'h5A, 4'h0, 8'h00, 2);
    chk("ram_ff_5a", ram[8'hFF], 8'h5A);
    run_op(0,0,1,1,1,0,0,0, 3'd2, 8'h00, 8'h00, 4'h0, 8'h00, 1);
    // CALL at PC=10 with flags 1010, then RTI
    run_op(0,0,0,1,0,0,1,1, 3'd0, 8'h00, 8'h77, 4'b1010, 8'h10, 1);
    chk("call_pc_byte", ram[8'hFF], 8'h11);
    chk("call_flag_byte", ram[8'hFE], 8'h0A);
    run_op(0,0,0,1,1,1,1,1, 3'd0, 8'h00, 8'h00, 4'h0, 8'h00, 2);
    // ALU pass-through
    run_op(0,0,1,0,0,0,0,0, 3'd4, 8'h00, 8'h33, 4'h0, 8'h00, 1);
    // Wrap both ways: pop at FF reads [00], push at 00 writes [00]
    run_op(0,0,1,1,1,0,0,0, 3'd1, 8'h00, 8'h00, 4'h0, 8'h00, 1);
    chk("sp_wrap_00", SP_Value, 8'h00);
    run_op(0,0,0,1,0,0,0,0, 3'd0, 8'h00, 8'hC3, 4'h0, 8'h00, 3);
    chk("ram_00_c3", ram[8'h00], 8'hC3);
    chk("sp_wrap_ff", SP_Value, 8'hFF);

    for (int t = 0; t < 30; t++) begin
      kind = $urandom_range(0, 6);
      lat  = $urandom_range(1, 3);
      d = 8'($urandom); ad = 8'($urandom); p = 8'($urandom);
      f = 4'($urandom); w = 3'($urandom);
      case (kind)
        0: run_op(0,0,1,0,0,0,0,0, w, ad, d, f, p, lat);
        1: run_op(1,0,1,0,0,0,0,0, w, ad, d, f, p, lat);
        2: run_op(0,1,0,0,0,0,0,0, w, ad, d, f, p, lat);
        3: run_op(0,0,0,1,0,0,0,0, w, ad, d, f, p, lat);
        4: run_op(0,0,1,1,1,0,0,0, w, ad, d, f, p, lat);
        5: run_op(0,0,0,1,0,0,1,1, w, ad, d, f, p, lat);
        default: run_op(0,0,1,1,1,1'($urandom),1,1, w, ad, d, f, p, lat);
      endcase
    end

    // Ack never arrives: error after 16 edges, stall released
    drive(1,0,1,0,0,0,0,0, 3'd5, 8'h20, 8'h44, 4'h0, 8'h00);
    @(negedge clk);
    in_valid = 1'b0;
    for (int k = 0; k < 16; k++) begin
      chk("to_req_held", mem_req, 1);
      @(negedge clk);
    end
    chk("to_err", mem_err, 1);
    chk("to_valid", out_valid, 1);
    chk("to_wb_out", WB_Out, 0);
    chk("to_pc_load", PC_Load, 0);
    chk("to_stall", stall, 0);
    chk("to_req", mem_req, 0);
    chk("to_sp", SP_Value, m_sp);
    @(negedge clk);
    chk("to_err_sticky", mem_err, 1);

    // Reset in the middle of an access
    drive(0,0,0,1,0,0,0,0, 3'd0, 8'h00, 8'h99, 4'h0, 8'h00);
    @(negedge clk);
    in_valid = 1'b0;
    chk("pre_rst_req", mem_req, 1);
    rst_n = 1'b0;
    #1;
    chk("async_req", mem_req, 0);
    chk("async_sp", SP_Value, 8'hFF);
    chk("async_err", mem_err, 0);
    chk("async_stall", stall, 0);
    m_sp = 8'hFF;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_op(0,0,0,1,0,0,0,0, 3'd0, 8'h00, 8'h44, 4'h0, 8'h00, 1);
    run_op(0,0,1,1,1,0,0,0, 3'd3, 8'h00, 8'h00, 4'h0, 8'h00, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
